// File: rtl/spi_ram_pkg.sv
// Shared command encodings and rx_data field positions for the SPI RAM controller.
package spi_ram_pkg;

    typedef logic [1:0] cmd_t;

    localparam cmd_t CMD_WR_ADDR = 2'b00;
    localparam cmd_t CMD_WR_DATA = 2'b01;
    localparam cmd_t CMD_RD_ADDR = 2'b10;
    localparam cmd_t CMD_RD_DATA = 2'b11;

    localparam int unsigned CMD_MSB  = 9;
    localparam int unsigned CMD_LSB  = 8;
    localparam int unsigned DATA_MSB = 7;

endpackage

// File: rtl/spi_ram_array.sv
// Single-port byte RAM with a registered, enable-held read port; storage is not reset.
module spi_ram_array #(
    parameter int unsigned MEM_DEPTH = 256,
    parameter int unsigned ADDR_SIZE = 8
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic                 re,
    input  logic [ADDR_SIZE-1:0] addr,
    input  logic [7:0]           din,
    output logic [7:0]           dout
);

    logic [7:0] mem [MEM_DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= din;
        end
        if (re) begin
            dout <= mem[addr];
        end
    end

endmodule

// File: rtl/spi_ram_ctrl.sv
// Decodes SPI slave command words into RAM writes and reads; returns read bytes on tx_data.
module spi_ram_ctrl
    import spi_ram_pkg::*;
#(
    parameter int unsigned MEM_DEPTH = 256,
    parameter int unsigned ADDR_SIZE = 8,
    parameter bit          AUTO_INC  = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    output logic       cmd_err
);

    cmd_t                 cmd;
    logic [ADDR_SIZE-1:0] rx_addr;
    logic [7:0]           rx_byte;
    logic [ADDR_SIZE-1:0] wr_addr_q, rd_addr_q, ram_addr;
    logic                 wr_addr_ok_q, rd_addr_ok_q;
    logic                 tx_valid_q, tx_zero_q, cmd_err_q;
    logic                 do_wr, do_rd;
    logic [7:0]           ram_dout;

    assign cmd     = rx_data[CMD_MSB:CMD_LSB];
    assign rx_addr = rx_data[ADDR_SIZE-1:0];
    assign rx_byte = rx_data[DATA_MSB:0];

    assign do_wr    = rx_valid && (cmd == CMD_WR_DATA) && wr_addr_ok_q;
    assign do_rd    = rx_valid && (cmd == CMD_RD_DATA) && rd_addr_ok_q;
    // One command per cycle, so a single shared port never sees a write and read together.
    assign ram_addr = do_wr ? wr_addr_q : rd_addr_q;

    spi_ram_array #(
        .MEM_DEPTH (MEM_DEPTH),
        .ADDR_SIZE (ADDR_SIZE)
    ) u_array (
        .clk  (clk),
        .we   (do_wr),
        .re   (do_rd),
        .addr (ram_addr),
        .din  (rx_byte),
        .dout (ram_dout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_addr_q    <= '0;
            rd_addr_q    <= '0;
            wr_addr_ok_q <= 1'b0;
            rd_addr_ok_q <= 1'b0;
            tx_valid_q   <= 1'b0;
            tx_zero_q    <= 1'b1;
            cmd_err_q    <= 1'b0;
        end else begin
            cmd_err_q <= 1'b0;
            if (rx_valid) begin
                tx_valid_q <= (cmd == CMD_RD_DATA);
                case (cmd)
                    CMD_WR_ADDR: begin
                        wr_addr_q    <= rx_addr;
                        wr_addr_ok_q <= 1'b1;
                    end
                    CMD_WR_DATA: begin
                        if (wr_addr_ok_q) begin
                            if (AUTO_INC) wr_addr_q <= wr_addr_q + ADDR_SIZE'(1);
                        end else begin
                            cmd_err_q <= 1'b1;
                        end
                    end
                    CMD_RD_ADDR: begin
                        rd_addr_q    <= rx_addr;
                        rd_addr_ok_q <= 1'b1;
                    end
                    default: begin
                        if (rd_addr_ok_q) begin
                            tx_zero_q <= 1'b0;
                            if (AUTO_INC) rd_addr_q <= rd_addr_q + ADDR_SIZE'(1);
                        end else begin
                            tx_zero_q <= 1'b1;
                            cmd_err_q <= 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    // tx_zero_q masks the RAM read register after reset or an unaddressed read.
    assign tx_data  = tx_zero_q ? 8'h00 : ram_dout;
    assign tx_valid = tx_valid_q;
    assign cmd_err  = cmd_err_q;

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Directed bench for spi_ram_ctrl: default, AUTO_INC and 4-bit address instances share stimulus.
module tb_spi_ram_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] rx_data = 10'h000;
    logic       rx_valid = 1'b0;
    logic [7:0] tx_data0, tx_data1, tx_data2;
    logic       tx_valid0, tx_valid1, tx_valid2;
    logic       cmd_err0, cmd_err1, cmd_err2;
    int         passed = 0;
    int         total = 0;

    always #5 clk = ~clk;

    spi_ram_ctrl #(.MEM_DEPTH(256), .ADDR_SIZE(8), .AUTO_INC(1'b0)) dut0 (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data0), .tx_valid(tx_valid0), .cmd_err(cmd_err0));

    spi_ram_ctrl #(.MEM_DEPTH(256), .ADDR_SIZE(8), .AUTO_INC(1'b1)) dut1 (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data1), .tx_valid(tx_valid1), .cmd_err(cmd_err1));

    spi_ram_ctrl #(.MEM_DEPTH(16), .ADDR_SIZE(4), .AUTO_INC(1'b0)) dut2 (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data2), .tx_valid(tx_valid2), .cmd_err(cmd_err2));

    // Called at a falling edge; returns at the next falling edge with results visible.
    task automatic put(input logic [1:0] c, input logic [7:0] d);
        rx_valid = 1'b1;
        rx_data  = {c, d};
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (tx_data0 !== 8'h00) $display("FAIL reset_tx_data got %h want 00", tx_data0); else passed++;
        total++; if (tx_valid0 !== 1'b0) $display("FAIL reset_tx_valid got %b want 0", tx_valid0); else passed++;
        total++; if (cmd_err0 !== 1'b0) $display("FAIL reset_cmd_err got %b want 0", cmd_err0); else passed++;
    endtask

    task automatic test_write_read();
        put(2'b00, 8'h00);
        put(2'b01, 8'h5A);
        put(2'b00, 8'h05);
        total++; if (cmd_err0 !== 1'b0) $display("FAIL wr_addr_err got %b want 0", cmd_err0); else passed++;
        put(2'b01, 8'hA5);
        total++; if (cmd_err0 !== 1'b0) $display("FAIL wr_data_err got %b want 0", cmd_err0); else passed++;
        put(2'b10, 8'h05);
        total++; if (tx_valid0 !== 1'b0) $display("FAIL rd_addr_tx_valid got %b want 0", tx_valid0); else passed++;
        put(2'b11, 8'h00);
        total++; if (tx_data0 !== 8'hA5) $display("FAIL rd_data got %h want a5", tx_data0); else passed++;
        total++; if (tx_valid0 !== 1'b1) $display("FAIL rd_tx_valid got %b want 1", tx_valid0); else passed++;
        @(negedge clk);
        @(negedge clk);
        total++; if (tx_valid0 !== 1'b1) $display("FAIL rd_hold_valid got %b want 1", tx_valid0); else passed++;
        total++; if (tx_data0 !== 8'hA5) $display("FAIL rd_hold_data got %h want a5", tx_data0); else passed++;
        put(2'b00, 8'h00);
        total++; if (tx_valid0 !== 1'b0) $display("FAIL rd_clear_valid got %b want 0", tx_valid0); else passed++;
        total++; if (tx_data0 !== 8'hA5) $display("FAIL rd_clear_data got %h want a5", tx_data0); else passed++;
    endtask

    task automatic test_no_addr_err();
        do_reset();
        put(2'b01, 8'h3C);
        total++; if (cmd_err0 !== 1'b1) $display("FAIL noaddr_wr_err got %b want 1", cmd_err0); else passed++;
        @(negedge clk);
        total++; if (cmd_err0 !== 1'b0) $display("FAIL noaddr_err_pulse got %b want 0", cmd_err0); else passed++;
        put(2'b11, 8'h00);
        total++; if (tx_data0 !== 8'h00) $display("FAIL noaddr_rd_data got %h want 00", tx_data0); else passed++;
        total++; if (tx_valid0 !== 1'b1) $display("FAIL noaddr_rd_valid got %b want 1", tx_valid0); else passed++;
        total++; if (cmd_err0 !== 1'b1) $display("FAIL noaddr_rd_err got %b want 1", cmd_err0); else passed++;
        put(2'b10, 8'h00);
        put(2'b11, 8'h00);
        total++; if (tx_data0 !== 8'h5A) $display("FAIL noaddr_no_write got %h want 5a", tx_data0); else passed++;
        total++; if (cmd_err0 !== 1'b0) $display("FAIL noaddr_ok_err got %b want 0", cmd_err0); else passed++;
    endtask

    task automatic test_gap();
        put(2'b10, 8'h05);
        put(2'b11, 8'h00);
        for (int i = 0; i < 20; i++) begin
            total++;
            if (tx_valid0 !== 1'b1) $display("FAIL gap_valid[%0d] got %b want 1", i, tx_valid0);
            else passed++;
            @(negedge clk);
        end
        put(2'b00, 8'h00);
        total++; if (tx_valid0 !== 1'b0) $display("FAIL gap_clear got %b want 0", tx_valid0); else passed++;
    endtask

    task automatic test_reset_mid();
        put(2'b10, 8'h05);
        put(2'b11, 8'h00);
        total++; if (tx_valid0 !== 1'b1) $display("FAIL mid_pre_valid got %b want 1", tx_valid0); else passed++;
        do_reset();
        total++; if (tx_valid0 !== 1'b0) $display("FAIL mid_valid got %b want 0", tx_valid0); else passed++;
        total++; if (tx_data0 !== 8'h00) $display("FAIL mid_data got %h want 00", tx_data0); else passed++;
        put(2'b10, 8'h05);
        put(2'b11, 8'h00);
        total++; if (tx_data0 !== 8'hA5) $display("FAIL mid_retained got %h want a5", tx_data0); else passed++;
        total++; if (tx_valid0 !== 1'b1) $display("FAIL mid_ret_valid got %b want 1", tx_valid0); else passed++;
    endtask

    task automatic test_back_to_back();
        do_reset();
        put(2'b00, 8'hFF);
        put(2'b01, 8'h11);
        put(2'b01, 8'h22);
        put(2'b10, 8'hFF);
        put(2'b11, 8'h00);
        total++; if (tx_data1 !== 8'h11) $display("FAIL inc_rd0 got %h want 11", tx_data1); else passed++;
        total++; if (tx_valid1 !== 1'b1) $display("FAIL inc_valid0 got %b want 1", tx_valid1); else passed++;
        total++; if (tx_data0 !== 8'h22) $display("FAIL noinc_rd0 got %h want 22", tx_data0); else passed++;
        put(2'b11, 8'h00);
        total++; if (tx_data1 !== 8'h22) $display("FAIL inc_wrap_rd1 got %h want 22", tx_data1); else passed++;
        total++; if (tx_valid1 !== 1'b1) $display("FAIL inc_valid1 got %b want 1", tx_valid1); else passed++;
        total++; if (tx_data0 !== 8'h22) $display("FAIL noinc_rd1 got %h want 22", tx_data0); else passed++;
    endtask

    task automatic test_addr_size4();
        do_reset();
        put(2'b00, 8'hF3);
        put(2'b01, 8'h77);
        put(2'b10, 8'h03);
        put(2'b11, 8'h00);
        total++; if (tx_data2 !== 8'h77) $display("FAIL a4_rd got %h want 77", tx_data2); else passed++;
        total++; if (tx_valid2 !== 1'b1) $display("FAIL a4_valid got %b want 1", tx_valid2); else passed++;
        total++; if (cmd_err2 !== 1'b0) $display("FAIL a4_err got %b want 0", cmd_err2); else passed++;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_write_read();
        test_no_addr_err();
        test_gap();
        test_reset_mid();
        test_back_to_back();
        test_addr_size4();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
